// File: rtl/ysyx_cdb_arb.sv
// CDB arbiter: each functional unit owns a one-entry slot; a round-robin pick drives one registered
// result beat per cycle into the ROB. Define YSYX_CDB_ARB_PERF_EN to add per-unit grant/stall counters.
module ysyx_cdb_arb #(
  parameter int  N_REQ    = 3,
  parameter int  XLEN     = 32,
  parameter int  ROB_SIZE = 4,
  parameter int  FLAG_W   = 8,
  localparam int TAG_W    = $clog2(ROB_SIZE) + 1,
  localparam int SRC_W    = $clog2(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush_pipeline,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*TAG_W-1:0]  req_dest,
  input  logic [N_REQ*XLEN-1:0]   req_result,
  input  logic [N_REQ*XLEN-1:0]   req_npc,
  input  logic [N_REQ*FLAG_W-1:0] req_flags,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_dest,
  output logic [XLEN-1:0]         cdb_result,
  output logic [XLEN-1:0]         cdb_npc,
  output logic [FLAG_W-1:0]       cdb_flags,
  output logic [SRC_W-1:0]        cdb_src
`ifdef YSYX_CDB_ARB_PERF_EN
  ,
  output logic [N_REQ*32-1:0]     perf_grant,
  output logic [N_REQ*32-1:0]     perf_stall
`endif
);

  logic [N_REQ-1:0]  slot_full_q;
  logic [TAG_W-1:0]  slot_dest_q   [N_REQ];
  logic [XLEN-1:0]   slot_result_q [N_REQ];
  logic [XLEN-1:0]   slot_npc_q    [N_REQ];
  logic [FLAG_W-1:0] slot_flags_q  [N_REQ];

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]  scan_idx [N_REQ];
  logic [SRC_W-1:0]  win_idx;
  logic              win_vld;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  accept;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_dest_q;
  logic [XLEN-1:0]   cdb_result_q;
  logic [XLEN-1:0]   cdb_npc_q;
  logic [FLAG_W-1:0] cdb_flags_q;
  logic [SRC_W-1:0]  cdb_src_q;

  // Scan order starting at rr_ptr; explicit wrap so non-power-of-two N_REQ never overflows.
  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      if (int'(rr_ptr_q) + k >= N_REQ) scan_idx[k] = SRC_W'(int'(rr_ptr_q) + k - N_REQ);
      else                             scan_idx[k] = SRC_W'(int'(rr_ptr_q) + k);
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any condition, so no path can infer a latch.
    win_vld  = 1'b0;
    win_idx  = '0;
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_vld && slot_full_q[scan_idx[k]]) begin
        win_vld = 1'b1;
        win_idx = scan_idx[k];
      end
    end
    if (flush_pipeline) win_vld = 1'b0;
    if (win_vld) begin
      grant[win_idx] = 1'b1;
      rr_ptr_d       = (win_idx == SRC_W'(N_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
    end
  end

  // A slot being drained this cycle can take a new result in the same cycle.
  assign req_ready = (~slot_full_q | grant) & {N_REQ{~flush_pipeline}};
  assign accept    = req_valid & req_ready;

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_full_q  <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_dest_q   <= '0;
      cdb_result_q <= '0;
      cdb_npc_q    <= '0;
      cdb_flags_q  <= '0;
      cdb_src_q    <= '0;
      // NOTE: payload storage is cleared on reset as well, so nothing stale survives a reset.
      for (int i = 0; i < N_REQ; i++) begin
        slot_dest_q[i]   <= '0;
        slot_result_q[i] <= '0;
        slot_npc_q[i]    <= '0;
        slot_flags_q[i]  <= '0;
      end
    end else if (flush_pipeline) begin
      slot_full_q <= '0;
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept[i]) begin
          slot_full_q[i]   <= 1'b1;
          slot_dest_q[i]   <= req_dest[i*TAG_W +: TAG_W];
          slot_result_q[i] <= req_result[i*XLEN +: XLEN];
          slot_npc_q[i]    <= req_npc[i*XLEN +: XLEN];
          slot_flags_q[i]  <= req_flags[i*FLAG_W +: FLAG_W];
        end else if (grant[i]) begin
          slot_full_q[i] <= 1'b0;
        end
      end
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= win_vld;
      if (win_vld) begin
        cdb_dest_q   <= slot_dest_q[win_idx];
        cdb_result_q <= slot_result_q[win_idx];
        cdb_npc_q    <= slot_npc_q[win_idx];
        cdb_flags_q  <= slot_flags_q[win_idx];
        cdb_src_q    <= win_idx;
      end
    end
  end

  assign cdb_valid  = cdb_valid_q;
  assign cdb_dest   = cdb_dest_q;
  assign cdb_result = cdb_result_q;
  assign cdb_npc    = cdb_npc_q;
  assign cdb_flags  = cdb_flags_q;
  assign cdb_src    = cdb_src_q;

`ifdef YSYX_CDB_ARB_PERF_EN
  logic [31:0] perf_grant_q [N_REQ];
  logic [31:0] perf_stall_q [N_REQ];

  // Saturating counters; a flush deliberately leaves them untouched.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (reset) begin
        perf_grant_q[i] <= '0;
        perf_stall_q[i] <= '0;
      end else begin
        if (grant[i] && perf_grant_q[i] != '1) perf_grant_q[i] <= perf_grant_q[i] + 32'd1;
        if (req_valid[i] && !req_ready[i] && perf_stall_q[i] != '1)
          perf_stall_q[i] <= perf_stall_q[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_perf
    assign perf_grant[g*32 +: 32] = perf_grant_q[g];
    assign perf_stall[g*32 +: 32] = perf_stall_q[g];
  end
`endif

`ifndef SYNTHESIS
  for (genvar g = 0; g < N_REQ; g++) begin : g_chk
    a_dest_nz: assert property (@(posedge clock) disable iff (reset)
      req_valid[g] |-> req_dest[g*TAG_W +: TAG_W] != '0);
    for (genvar h = g + 1; h < N_REQ; h++) begin : g_pair
      a_tag_uniq: assert property (@(posedge clock) disable iff (reset)
        !(slot_full_q[g] && slot_full_q[h] && slot_dest_q[g] == slot_dest_q[h]));
    end
  end
  a_grant_1hot: assert property (@(posedge clock) disable iff (reset) $onehot0(grant));
`endif

endmodule

// File: tb/tb_ysyx_cdb_arb.sv
// Directed self-checking bench for ysyx_cdb_arb (N_REQ=3); perf counters checked when
// YSYX_CDB_ARB_PERF_EN is defined.
module tb_ysyx_cdb_arb;
  localparam int N_REQ  = 3;
  localparam int XLEN   = 32;
  localparam int TAG_W  = 3;
  localparam int FLAG_W = 8;
  localparam int SRC_W  = 2;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    flush_pipeline = 1'b0;
  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*TAG_W-1:0]  req_dest = '0;
  logic [N_REQ*XLEN-1:0]   req_result = '0;
  logic [N_REQ*XLEN-1:0]   req_npc = '0;
  logic [N_REQ*FLAG_W-1:0] req_flags = '0;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_dest;
  logic [XLEN-1:0]         cdb_result;
  logic [XLEN-1:0]         cdb_npc;
  logic [FLAG_W-1:0]       cdb_flags;
  logic [SRC_W-1:0]        cdb_src;
`ifdef YSYX_CDB_ARB_PERF_EN
  logic [N_REQ*32-1:0]     perf_grant;
  logic [N_REQ*32-1:0]     perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_grant [N_REQ];
  int exp_stall [N_REQ];
  int seen_cnt  [N_REQ];

  ysyx_cdb_arb #(.N_REQ(N_REQ), .XLEN(XLEN), .ROB_SIZE(4), .FLAG_W(FLAG_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush_pipeline (flush_pipeline),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dest       (req_dest),
    .req_result     (req_result),
    .req_npc        (req_npc),
    .req_flags      (req_flags),
    .cdb_valid      (cdb_valid),
    .cdb_dest       (cdb_dest),
    .cdb_result     (cdb_result),
    .cdb_npc        (cdb_npc),
    .cdb_flags      (cdb_flags),
    .cdb_src        (cdb_src)
`ifdef YSYX_CDB_ARB_PERF_EN
    ,
    .perf_grant     (perf_grant),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int u, input int dest, input logic [31:0] res);
    req_valid[u]                  = 1'b1;
    req_dest[u*TAG_W +: TAG_W]    = TAG_W'(dest);
    req_result[u*XLEN +: XLEN]    = res;
    req_npc[u*XLEN +: XLEN]       = ~res;
    req_flags[u*FLAG_W +: FLAG_W] = res[7:0];
  endtask

  task automatic clr_all();
    req_valid = '0;
  endtask

  // Payload convention: npc = ~result, flags = result[7:0].
  task automatic expect_beat(input string tag, input int src, input int dest, input logic [31:0] res);
    logic [31:0] npc;
    npc = ~res;
    check({tag, ".valid"},  cdb_valid, 1);
    check({tag, ".src"},    cdb_src, src);
    check({tag, ".dest"},   cdb_dest, dest);
    check({tag, ".result"}, cdb_result, res);
    check({tag, ".npc"},    cdb_npc, npc);
    check({tag, ".flags"},  cdb_flags, res[7:0]);
    exp_grant[src]++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"},  cdb_valid, 0);
    check({tag, ".dest"},   cdb_dest, 0);
    check({tag, ".result"}, cdb_result, 0);
    check({tag, ".npc"},    cdb_npc, 0);
    check({tag, ".flags"},  cdb_flags, 0);
    check({tag, ".src"},    cdb_src, 0);
  endtask

  initial begin
    for (int u = 0; u < N_REQ; u++) begin
      exp_grant[u] = 0;
      exp_stall[u] = 0;
      seen_cnt[u]  = 0;
    end

    // Reset for two cycles, outputs must all read zero.
    repeat (2) @(negedge clock);
    #1;
    check_zero("rst");
    reset = 1'b0;

    // Single request from unit 1: accepted in cycle t, beat in t+2.
    repeat (2) @(negedge clock);
    @(negedge clock); set_req(1, 3, 32'hDEADBEEF); #1;
    check("t1.ready", req_ready, 3'b111);
    check("t1.c0_valid", cdb_valid, 0);
    @(negedge clock); clr_all(); #1;
    check("t1.c1_valid", cdb_valid, 0);
    @(negedge clock); #1;
    expect_beat("t1.beat", 1, 3, 32'hDEADBEEF);
    @(negedge clock); #1;
    check("t1.after_valid", cdb_valid, 0);
    check("t1.hold_dest", cdb_dest, 3);

    // Flush pulse with nothing pending: blocks accepts, returns rr_ptr to 0.
    @(negedge clock); flush_pipeline = 1'b1; #1;
    check("fl0.ready", req_ready, 3'b000);
    @(negedge clock); flush_pipeline = 1'b0;

    // Simultaneous requests: beats in order 0,1,2.
    set_req(0, 1, 32'h100); set_req(1, 2, 32'h101); set_req(2, 3, 32'h102); #1;
    check("t2.ready0", req_ready, 3'b111);
    @(negedge clock); clr_all(); #1;
    check("t2.ready1", req_ready, 3'b001);
    check("t2.idle", cdb_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock); #1;
      expect_beat("t2.beat", k, k + 1, 32'h100 + k);
    end

    // rr_ptr wrapped to 0: units 1 and 2 together must go 1 then 2.
    @(negedge clock); set_req(1, 2, 32'h201); set_req(2, 3, 32'h202); #1;
    check("t2w.idle", cdb_valid, 0);
    @(negedge clock); clr_all();
    @(negedge clock); #1;
    expect_beat("t2w.first", 1, 2, 32'h201);
    @(negedge clock); #1;
    expect_beat("t2w.second", 2, 3, 32'h202);

    // Reset while the beat registers hold data.
    @(negedge clock); reset = 1'b1;
    @(negedge clock); #1;
    check_zero("rst2");
    reset = 1'b0;
    for (int u = 0; u < N_REQ; u++) begin
      exp_grant[u] = 0;
      exp_stall[u] = 0;
    end

    // Continuous contention for 30 cycles, then drain.
    for (int n = 0; n < 36; n++) begin
      logic [N_REQ-1:0] exp_rdy;
      @(negedge clock);
      if (n < 30) begin
        for (int u = 0; u < N_REQ; u++) set_req(u, u + 1, 32'hA0 + u);
      end else begin
        clr_all();
      end
      #1;
      if (n < 30) begin
        exp_rdy = (n == 0) ? 3'b111 : N_REQ'(1 << ((n - 1) % 3));
        check("t3.ready", req_ready, exp_rdy);
        for (int u = 0; u < N_REQ; u++) if (!exp_rdy[u]) exp_stall[u]++;
      end
      if (n >= 2 && n <= 33) begin
        if (n <= 31 && cdb_valid && cdb_src < 2'd3) seen_cnt[cdb_src]++;
        expect_beat("t3.beat", (n - 2) % 3, ((n - 2) % 3) + 1, 32'hA0 + ((n - 2) % 3));
      end else if (n > 33) begin
        check("t3.drained", cdb_valid, 0);
      end
    end
    for (int u = 0; u < N_REQ; u++) check("t3.fair", seen_cnt[u], 10);

    // Flush with slots 0 and 2 full and a beat on the bus; rr_ptr is 2 going in.
    @(negedge clock); set_req(1, 2, 32'h501); #1;
    check("t5.r0", req_ready, 3'b111);
    @(negedge clock); clr_all(); set_req(0, 1, 32'h500); set_req(2, 3, 32'h502); #1;
    check("t5.r1", req_ready, 3'b111);
    @(negedge clock); clr_all(); flush_pipeline = 1'b1; set_req(1, 4, 32'h5FF); #1;
    check("t5.flush_ready", req_ready, 3'b000);
    expect_beat("t5.pre_flush", 1, 2, 32'h501);
    exp_stall[1]++;
    @(negedge clock); flush_pipeline = 1'b0; clr_all(); #1;
    check("t5.squash", cdb_valid, 0);
    check("t5.ready_empty", req_ready, 3'b111);
    @(negedge clock); set_req(1, 5, 32'h511); set_req(2, 6, 32'h512); #1;
    check("t5.no_stale", cdb_valid, 0);
    @(negedge clock); clr_all(); #1;
    check("t5.no_capture", cdb_valid, 0);
    @(negedge clock); #1;
    expect_beat("t5.post1", 1, 5, 32'h511);
    @(negedge clock); #1;
    expect_beat("t5.post2", 2, 6, 32'h512);
    @(negedge clock); #1;
    check("t5.end", cdb_valid, 0);

`ifdef YSYX_CDB_ARB_PERF_EN
    for (int u = 0; u < N_REQ; u++) begin
      check("perf.grant", perf_grant[u*32 +: 32], exp_grant[u]);
      check("perf.stall", perf_stall[u*32 +: 32], exp_stall[u]);
    end
`endif

    // Unit 2 alone for five cycles: refilled on every grant.
    for (int n = 0; n < 8; n++) begin
      @(negedge clock);
      if (n < 5) set_req(2, n + 1, 32'h2000 + n);
      else clr_all();
      #1;
      if (n < 5) check("t4.ready2", req_ready[2], 1);
      if (n >= 2 && n <= 6) expect_beat("t4.beat", 2, n - 1, 32'h2000 + n - 2);
      else if (n == 7) check("t4.idle", cdb_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
